// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with write-to-read bypass
// and a per-register busy scoreboard (decode claims, writeback releases).
//
// After reset a sweep zeroes registers 1..NREG-1, one per cycle; ready_o is
// low until the sweep has written the last register.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   ready_o      1 = clear sweep done, file usable
//   we_i         write enable per write port
//   waddr_i      write address, port i at [i*AW +: AW]
//   wdata_i      write data, port i at [i*XLEN +: XLEN]
//   re_i         read enable per read port
//   raddr_i      read address, port j at [j*AW +: AW]
//   rdata_o      read data, port j at [j*XLEN +: XLEN] (combinational)
//   rbusy_o      1 = addressed register has a pending write (combinational)
//   claim_en_i   mark claim_addr_i busy
//   claim_addr_i destination register being claimed
//   busy_vec_o   full scoreboard, bit 0 always 0
module regfile_mp_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready_o,
    input  logic [NWR-1:0]      we_i,
    input  logic [NWR*AW-1:0]   waddr_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    input  logic [NRD-1:0]      re_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic                claim_en_i,
    input  logic [AW-1:0]       claim_addr_i,
    output logic [NREG-1:0]     busy_vec_o
);

    localparam bit BYP = (BYPASS != 0);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              clr_we;
    logic              run;

    logic [XLEN-1:0]   mem_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;

    logic [AW-1:0]     wa     [NWR];
    logic [XLEN-1:0]   wd     [NWR];
    logic [NWR-1:0]    wr_ok;
    logic [AW-1:0]     ra     [NRD];
    logic [NRD-1:0]    hit;
    logic [XLEN-1:0]   byp_d  [NRD];

    // ------------------------------------------------------------------
    // Port unpacking
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wa[i] = waddr_i[i*AW +: AW];
            wd[i] = wdata_i[i*XLEN +: XLEN];
        end
        for (int j = 0; j < NRD; j++) begin
            ra[j] = raddr_i[j*AW +: AW];
        end
    end

    assign run     = (state_q == S_RUN);
    assign ready_o = run;

    // A write counts only in RUN and only to a non-zero register.
    always_comb begin
        wr_ok = '0;
        for (int i = 0; i < NWR; i++) begin
            wr_ok[i] = run && we_i[i] && (wa[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset; the sweep initialises it).
    // Later ports are assigned last so the highest index wins a collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[cnt_q] <= '0;
            end else begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_ok[i]) begin
                        mem_q[wa[i]] <= wd[i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: releases first, then a claim, so a claim on the same
    // register as a release leaves it busy.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_ok[i]) begin
                    busy_d[wa[i]] = 1'b0;
                end
            end
            if (claim_en_i && (claim_addr_i != '0)) begin
                busy_d[claim_addr_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    // ------------------------------------------------------------------
    // Read ports: find the highest-index same-cycle write to the address.
    // ------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            hit[j]   = 1'b0;
            byp_d[j] = '0;
            for (int i = 0; i < NWR; i++) begin
                if (wr_ok[i] && (wa[i] == ra[j])) begin
                    hit[j]   = 1'b1;
                    byp_d[j] = wd[i];
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int j = 0; j < NRD; j++) begin
            if (rst || !run) begin
                rdata_o[j*XLEN +: XLEN] = '0;
            end else if (ra[j] == '0) begin
                rdata_o[j*XLEN +: XLEN] = '0;
            end else if (!re_i[j]) begin
                rdata_o[j*XLEN +: XLEN] = '0;
            end else if (BYP && hit[j]) begin
                rdata_o[j*XLEN +: XLEN] = byp_d[j];
            end else begin
                rdata_o[j*XLEN +: XLEN] = mem_q[ra[j]];
            end
            rbusy_o[j] = run && re_i[j] && (ra[j] != '0)
                       && busy_q[ra[j]] && !(BYP && hit[j]);
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed and randomized checks of regfile_mp_sb against
// an array-based reference model of the register file and scoreboard.
module tb_regfile_mp_sb;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int BYPASS = 1;
    localparam int AW     = $clog2(NREG);

    logic                clk;
    logic                rst;
    logic                ready;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD-1:0]      re;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                claim_en;
    logic [AW-1:0]       claim_addr;
    logic [NREG-1:0]     busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [XLEN-1:0] m_mem [NREG];
    logic [NREG-1:0] m_busy;
    bit              m_ready;
    int              m_sweep;

    regfile_mp_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ready_o(ready),
        .we_i(we),
        .waddr_i(waddr),
        .wdata_i(wdata),
        .re_i(re),
        .raddr_i(raddr),
        .rdata_o(rdata),
        .rbusy_o(rbusy),
        .claim_en_i(claim_en),
        .claim_addr_i(claim_addr),
        .busy_vec_o(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] wa(int i);
        return waddr[i*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] wd(int i);
        return wdata[i*XLEN +: XLEN];
    endfunction

    function automatic logic [AW-1:0] ra(int j);
        return raddr[j*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] rd(int j);
        return rdata[j*XLEN +: XLEN];
    endfunction

    // Index of the last write port writing addr this cycle, or -1.
    function automatic int fwd_port(logic [AW-1:0] a);
        int p = -1;
        for (int i = 0; i < NWR; i++) begin
            if (m_ready && we[i] && wa(i) != 0 && wa(i) == a) p = i;
        end
        return p;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(int j);
        int p;
        if (rst || !m_ready) return '0;
        if (ra(j) == 0) return '0;
        if (!re[j]) return '0;
        p = fwd_port(ra(j));
        if (BYPASS != 0 && p >= 0) return wd(p);
        return m_mem[ra(j)];
    endfunction

    function automatic logic exp_rbusy(int j);
        if (!m_ready || !re[j] || ra(j) == 0) return 1'b0;
        if (BYPASS != 0 && fwd_port(ra(j)) >= 0) return 1'b0;
        return m_busy[ra(j)];
    endfunction

    task automatic model_update();
        if (rst) begin
            m_ready = 0;
            m_sweep = 0;
            m_busy  = '0;
        end else if (!m_ready) begin
            m_sweep++;
            m_mem[m_sweep] = '0;
            if (m_sweep == NREG - 1) m_ready = 1;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && wa(i) != 0) begin
                    m_mem[wa(i)]  = wd(i);
                    m_busy[wa(i)] = 1'b0;
                end
            end
            if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
        end
    endtask

    // Inputs change only at negedge; the model steps on the posedge.
    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        re = '0; raddr = '0;
        claim_en = 1'b0; claim_addr = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int c = 0; c < NREG - 1; c++) begin
            re = '1;
            for (int j = 0; j < NRD; j++) raddr[j*AW +: AW] = rnd_addr();
            we = '1;
            waddr = {NWR{AW'(3)}};
            wdata = {NWR{64'hFFFF_0000_FFFF_0000}};
            claim_en = 1'b1; claim_addr = AW'(4);
            #1;
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready c=%0d got=%b exp=0", c, ready);
            end
            n_checks++;
            if (rdata !== '0 || rbusy !== '0) begin
                n_fail++;
                $display("FAIL reset_rdata c=%0d got=%h/%b exp=0", c, rdata, rbusy);
            end
            cyc();
        end
        idle();
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_end got=%b exp=1", ready);
        end
        n_checks++;
        if (busy_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_busy got=%h exp=0", busy_vec);
        end
        re = '1; raddr = {AW'(4), AW'(3)};
        #1;
        n_checks++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL sweep_zero got=%h exp=0", rdata);
        end
        cyc();
    endtask

    task automatic test_write_read();
        idle();
        we[0] = 1'b1; waddr[0 +: AW] = AW'(5); wdata[0 +: XLEN] = 64'hDEAD;
        cyc();
        idle();
        re = '1;
        raddr[0 +: AW] = AW'(5);
        raddr[AW +: AW] = AW'(0);
        #1;
        n_checks++;
        if (rd(0) !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL read5 got=%h exp=%h", rd(0), 64'hDEAD);
        end
        n_checks++;
        if (rd(1) !== 64'h0) begin
            n_fail++;
            $display("FAIL read0 got=%h exp=0", rd(1));
        end
        re = 2'b10; raddr[AW +: AW] = AW'(5);
        #1;
        n_checks++;
        if (rd(0) !== 64'h0 || rd(1) !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL read_en got=%h exp=%h", rdata, {64'hDEAD, 64'h0});
        end
        cyc();
    endtask

    task automatic test_collision();
        idle();
        we = 2'b11;
        waddr = {AW'(7), AW'(7)};
        wdata = {64'h22, 64'h11};
        re[0] = 1'b1; raddr[0 +: AW] = AW'(7);
        #1;
        n_checks++;
        if (rd(0) !== 64'h22) begin
            n_fail++;
            $display("FAIL coll_bypass got=%h exp=22", rd(0));
        end
        cyc();
        we = '0;
        #1;
        n_checks++;
        if (rd(0) !== 64'h22) begin
            n_fail++;
            $display("FAIL coll_store got=%h exp=22", rd(0));
        end
        cyc();
    endtask

    task automatic test_claim();
        idle();
        claim_en = 1'b1; claim_addr = AW'(9);
        cyc();
        idle();
        re[0] = 1'b1; raddr[0 +: AW] = AW'(9);
        #1;
        n_checks++;
        if (busy_vec[9] !== 1'b1 || rbusy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL claim9 got=%b/%b exp=1/1", busy_vec[9], rbusy[0]);
        end
        claim_en = 1'b1; claim_addr = AW'(9);
        we[1] = 1'b1; waddr[AW +: AW] = AW'(9); wdata[XLEN +: XLEN] = 64'h99;
        #1;
        n_checks++;
        if (rbusy[0] !== 1'b0 || rd(0) !== 64'h99) begin
            n_fail++;
            $display("FAIL claim_wr_byp got=%b/%h exp=0/99", rbusy[0], rd(0));
        end
        cyc();
        idle();
        #1;
        n_checks++;
        if (busy_vec[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL claim_wins got=%b exp=1", busy_vec[9]);
        end
        cyc();
    endtask

    task automatic test_release_x0();
        idle();
        we[0] = 1'b1; waddr[0 +: AW] = AW'(9); wdata[0 +: XLEN] = 64'h1234;
        cyc();
        idle();
        re[0] = 1'b1; raddr[0 +: AW] = AW'(9);
        #1;
        n_checks++;
        if (busy_vec[9] !== 1'b0 || rbusy[0] !== 1'b0 || rd(0) !== 64'h1234) begin
            n_fail++;
            $display("FAIL release9 got=%b/%b/%h exp=0/0/1234", busy_vec[9], rbusy[0], rd(0));
        end
        claim_en = 1'b1; claim_addr = AW'(0);
        we = 2'b11; waddr = '0; wdata = {NWR{64'hFF}};
        re = '1; raddr = '0;
        #1;
        n_checks++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL x0_byp got=%h exp=0", rdata);
        end
        cyc();
        idle();
        re = '1;
        #1;
        n_checks++;
        if (rdata !== '0 || busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_after got=%h/%h exp=0/0", rdata, busy_vec);
        end
        cyc();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NWR; i++) begin
                we[i] = ($urandom_range(0, 2) != 0);
                waddr[i*AW +: AW] = rnd_addr();
                wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
            end
            for (int j = 0; j < NRD; j++) begin
                re[j] = ($urandom_range(0, 3) != 0);
                raddr[j*AW +: AW] = rnd_addr();
            end
            claim_en = ($urandom_range(0, 1) == 1);
            claim_addr = rnd_addr();
            #1;
            for (int j = 0; j < NRD; j++) begin
                n_checks++;
                if (rd(j) !== exp_rd(j)) begin
                    n_fail++;
                    $display("FAIL rnd_rdata c=%0d p=%0d got=%h exp=%h", c, j, rd(j), exp_rd(j));
                end
                n_checks++;
                if (rbusy[j] !== exp_rbusy(j)) begin
                    n_fail++;
                    $display("FAIL rnd_rbusy c=%0d p=%0d got=%b exp=%b", c, j, rbusy[j], exp_rbusy(j));
                end
            end
            n_checks++;
            if (busy_vec !== m_busy || ready !== m_ready) begin
                n_fail++;
                $display("FAIL rnd_busy c=%0d got=%h/%b exp=%h/%b", c, busy_vec, ready, m_busy, m_ready);
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_reset_midsweep();
        idle();
        we[0] = 1'b1; waddr[0 +: AW] = AW'(12); wdata[0 +: XLEN] = 64'hABCD;
        claim_en = 1'b1; claim_addr = AW'(3);
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int c = 0; c < NREG - 1; c++) begin
            #1;
            n_checks++;
            if (ready !== 1'b0 || busy_vec !== '0) begin
                n_fail++;
                $display("FAIL mid_sweep c=%0d got=%b/%h exp=0/0", c, ready, busy_vec);
            end
            cyc();
        end
        re = '1; raddr = {AW'(3), AW'(12)};
        #1;
        n_checks++;
        if (ready !== 1'b1 || busy_vec !== '0) begin
            n_fail++;
            $display("FAIL mid_ready got=%b/%h exp=1/0", ready, busy_vec);
        end
        n_checks++;
        if (rdata !== '0 || rbusy !== '0) begin
            n_fail++;
            $display("FAIL mid_clear got=%h/%b exp=0/0", rdata, rbusy);
        end
        cyc();
        idle();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) m_mem[r] = '0;
        m_busy = '0; m_ready = 0; m_sweep = 0;
        rst = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_collision();
        test_claim();
        test_release_x0();
        test_random();
        test_reset_midsweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
